// File: rtl/operand_entry_ctrl.sv
// Operand entry sequencer: synchronises and debounces enter/clear, then writes A, then B, then pulses calc_go.
// Optional WAIT_B idle timeout is compiled in with `define ENTRY_TIMEOUT_EN.
module operand_entry_ctrl #(
    parameter int DATA_W          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              btn_enter,
    input  logic              btn_clear,
    output logic              write_addr,
    output logic              load,
    output logic [DATA_W-1:0] load_data,
    output logic              calc_go,
    output logic [1:0]        state_o
);

    localparam int            CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_A = 2'b00,
        WAIT_B = 2'b01,
        GO     = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Bit 0 is enter, bit 1 is clear; both buttons share one input path.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_d;
    logic [1:0]    db_dly_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    press;
    logic          enter_press;
    logic          clear_press;

    assign btn_raw = {btn_clear, btn_enter};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign press       = db_q & ~db_dly_q;
    assign enter_press = press[0];
    assign clear_press = press[1];

    state_t            state_q;
    logic              load_q;
    logic              calc_go_q;
    logic              write_addr_q;
    logic [DATA_W-1:0] load_data_q;
`ifdef ENTRY_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]            idle_q;
`endif

    // Strobes default low so load and calc_go can only ever last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE_A;
            load_q       <= 1'b0;
            calc_go_q    <= 1'b0;
            write_addr_q <= 1'b0;
            load_data_q  <= '0;
`ifdef ENTRY_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            load_q    <= 1'b0;
            calc_go_q <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            idle_q    <= '0;
`endif
            if (clear_press) begin
                state_q <= IDLE_A;
            end else begin
                case (state_q)
                    IDLE_A, DONE: begin
                        if (enter_press) begin
                            load_q       <= 1'b1;
                            write_addr_q <= 1'b0;
                            load_data_q  <= sw_data;
                            state_q      <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (enter_press) begin
                            load_q       <= 1'b1;
                            write_addr_q <= 1'b1;
                            load_data_q  <= sw_data;
                            state_q      <= GO;
                        end
`ifdef ENTRY_TIMEOUT_EN
                        else if (idle_q == IDLE_MAX) begin
                            state_q <= IDLE_A;
                        end else begin
                            idle_q <= idle_q + TW'(1);
                        end
`endif
                    end
                    GO: begin
                        calc_go_q <= 1'b1;
                        state_q   <= DONE;
                    end
                endcase
            end
        end
    end

    assign write_addr = write_addr_q;
    assign load       = load_q;
    assign load_data  = load_data_q;
    assign calc_go    = calc_go_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_operand_entry_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_data;
    logic       btn_enter;
    logic       btn_clear;
    logic       write_addr;
    logic       load;
    logic [3:0] load_data;
    logic       calc_go;
    logic [1:0] state_o;

    int checks;
    int failures;
    int cyc;
    int load_cnt;
    int go_cnt;
    int last_load_cyc;
    int last_go_cyc;
    int viol;
    logic prev_load;
    logic prev_go;

    operand_entry_ctrl #(
        .DATA_W(4),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_data(sw_data),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .write_addr(write_addr),
        .load(load),
        .load_data(load_data),
        .calc_go(calc_go),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (load) begin
            load_cnt++;
            last_load_cyc = cyc;
        end
        if (calc_go) begin
            go_cnt++;
            last_go_cyc = cyc;
        end
        if ((load && calc_go) || (load && prev_load) || (calc_go && prev_go)) viol++;
        prev_load = load;
        prev_go   = calc_go;
    end

    // Hold enter for 'hold' cycles, release, then let the release debounce settle.
    task automatic press_enter(input logic [3:0] sw, input int hold);
        sw_data   = sw;
        btn_enter = 1'b1;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL reset_state got=%0h exp=0", state_o); end
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%0b exp=0", load); end
        checks++; if (calc_go !== 1'b0) begin failures++; $display("FAIL reset_calc_go got=%0b exp=0", calc_go); end
        checks++; if (write_addr !== 1'b0) begin failures++; $display("FAIL reset_write_addr got=%0b exp=0", write_addr); end
        checks++; if (load_data !== 4'h0) begin failures++; $display("FAIL reset_load_data got=%0h exp=0", load_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequence;
        int l0;
        int g0;
        l0 = load_cnt;
        sw_data   = 4'hA;
        btn_enter = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL latency_early got=%0b exp=0", load); end
        @(negedge clk);
        checks++; if (load !== 1'b1) begin failures++; $display("FAIL latency_load got=%0b exp=1", load); end
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (load_cnt !== l0 + 1) begin failures++; $display("FAIL seq_a_count got=%0d exp=%0d", load_cnt, l0 + 1); end
        checks++; if (write_addr !== 1'b0) begin failures++; $display("FAIL seq_a_addr got=%0b exp=0", write_addr); end
        checks++; if (load_data !== 4'hA) begin failures++; $display("FAIL seq_a_data got=%0h exp=a", load_data); end
        checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL seq_a_state got=%0h exp=1", state_o); end
        g0 = go_cnt;
        press_enter(4'h3, 10);
        checks++; if (load_cnt !== l0 + 2) begin failures++; $display("FAIL seq_b_count got=%0d exp=%0d", load_cnt, l0 + 2); end
        checks++; if (write_addr !== 1'b1) begin failures++; $display("FAIL seq_b_addr got=%0b exp=1", write_addr); end
        checks++; if (load_data !== 4'h3) begin failures++; $display("FAIL seq_b_data got=%0h exp=3", load_data); end
        checks++; if (go_cnt !== g0 + 1) begin failures++; $display("FAIL seq_go_count got=%0d exp=%0d", go_cnt, g0 + 1); end
        checks++; if (last_go_cyc !== last_load_cyc + 1) begin failures++; $display("FAIL seq_go_timing got=%0d exp=%0d", last_go_cyc, last_load_cyc + 1); end
        checks++; if (state_o !== 2'b11) begin failures++; $display("FAIL seq_done_state got=%0h exp=3", state_o); end
    endtask

    task automatic test_done_reload;
        int l0;
        l0 = load_cnt;
        press_enter(4'h5, 10);
        checks++; if (load_cnt !== l0 + 1) begin failures++; $display("FAIL reload_count got=%0d exp=%0d", load_cnt, l0 + 1); end
        checks++; if (write_addr !== 1'b0) begin failures++; $display("FAIL reload_addr got=%0b exp=0", write_addr); end
        checks++; if (load_data !== 4'h5) begin failures++; $display("FAIL reload_data got=%0h exp=5", load_data); end
        checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL reload_state got=%0h exp=1", state_o); end
        press_enter(4'h9, 10);
        checks++; if (state_o !== 2'b11) begin failures++; $display("FAIL reload_b_state got=%0h exp=3", state_o); end
    endtask

    task automatic test_clear_keep;
        int l0;
        int g0;
        l0 = load_cnt;
        g0 = go_cnt;
        sw_data   = 4'h6;
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_clear = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL clear_state got=%0h exp=0", state_o); end
        checks++; if (write_addr !== 1'b1) begin failures++; $display("FAIL clear_keep_addr got=%0b exp=1", write_addr); end
        checks++; if (load_data !== 4'h9) begin failures++; $display("FAIL clear_keep_data got=%0h exp=9", load_data); end
        checks++; if (load_cnt !== l0 || go_cnt !== g0) begin failures++; $display("FAIL clear_no_pulse got=%0d/%0d exp=%0d/%0d", load_cnt, go_cnt, l0, g0); end
    endtask

    task automatic test_clear_enter;
        int l0;
        press_enter(4'h2, 10);
        checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL ce_pre_state got=%0h exp=1", state_o); end
        l0 = load_cnt;
        sw_data   = 4'hE;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL ce_state got=%0h exp=0", state_o); end
        checks++; if (load_cnt !== l0) begin failures++; $display("FAIL ce_no_load got=%0d exp=%0d", load_cnt, l0); end
        checks++; if (load_data !== 4'h2) begin failures++; $display("FAIL ce_keep_data got=%0h exp=2", load_data); end
    endtask

    task automatic test_short_pulse;
        int l0;
        l0 = load_cnt;
        sw_data   = 4'h4;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (load_cnt !== l0) begin failures++; $display("FAIL short_no_load got=%0d exp=%0d", load_cnt, l0); end
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL short_state got=%0h exp=0", state_o); end
    endtask

    task automatic test_held;
        int l0;
        l0 = load_cnt;
        sw_data   = 4'h7;
        btn_enter = 1'b1;
        repeat (7) @(negedge clk);
        checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL held_state_at_load got=%0h exp=1", state_o); end
        repeat (43) @(negedge clk);
        btn_enter = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (load_cnt !== l0 + 1) begin failures++; $display("FAIL held_one_load got=%0d exp=%0d", load_cnt, l0 + 1); end
`ifdef ENTRY_TIMEOUT_EN
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL held_state got=%0h exp=0", state_o); end
`else
        checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL held_state got=%0h exp=1", state_o); end
`endif
    endtask

    task automatic test_reset_mid;
        int l0;
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_clear = 1'b0;
        repeat (8) @(negedge clk);
        press_enter(4'hB, 10);
        checks++; if (state_o !== 2'b01 || load_data !== 4'hB) begin failures++; $display("FAIL rm_pre got=%0h/%0h exp=1/b", state_o, load_data); end
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL rm_async_state got=%0h exp=0", state_o); end
        checks++; if (load_data !== 4'h0) begin failures++; $display("FAIL rm_async_data got=%0h exp=0", load_data); end
        checks++; if (load !== 1'b0 || calc_go !== 1'b0 || write_addr !== 1'b0) begin failures++; $display("FAIL rm_async_ctrl got=%0b%0b%0b exp=000", load, calc_go, write_addr); end
        btn_enter = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        l0 = load_cnt;
        repeat (15) @(negedge clk);
        checks++; if (load_cnt !== l0) begin failures++; $display("FAIL rm_no_load got=%0d exp=%0d", load_cnt, l0); end
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL rm_state got=%0h exp=0", state_o); end
    endtask

    task automatic test_timeout;
        sw_data   = 4'h1;
        btn_enter = 1'b1;
        repeat (7) @(negedge clk);
        checks++; if (load !== 1'b1) begin failures++; $display("FAIL to_load got=%0b exp=1", load); end
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL to_state_15 got=%0h exp=1", state_o); end
        repeat (10) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
        checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL to_state_25 got=%0h exp=0", state_o); end
`else
        checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL to_state_25 got=%0h exp=1", state_o); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        load_cnt = 0;
        go_cnt = 0;
        last_load_cyc = 0;
        last_go_cyc = 0;
        viol = 0;
        prev_load = 1'b0;
        prev_go = 1'b0;
        rst_n = 1'b0;
        sw_data = 4'h0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;

        test_reset;
        test_sequence;
        test_done_reload;
        test_clear_keep;
        test_clear_enter;
        test_short_pulse;
        test_held;
        test_reset_mid;
        test_timeout;

        checks++; if (viol !== 0) begin failures++; $display("FAIL pulse_rules got=%0d exp=0", viol); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
